// File: rtl/data_mem_resp.sv
// data_mem_resp: fixed-latency data memory; req (valid/ready, addr, wen, memop, wdata) in, resp (valid/ready, rdata, err) out
module data_mem_resp #(
  parameter logic [31:0] BASE = 32'h80000000,
  parameter int DEPTH = 4096,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIM = 33'(DEPTH) << 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] a_addr, a_wdata;
  logic a_wen;
  logic [2:0] a_memop;
  logic [31:0] mem [DEPTH];
  logic accept, enter, err, c_wen;
  logic [31:0] c_addr, c_wdata, off, word, lsh, ld, wd;
  logic [2:0] c_memop;
  logic [AW-1:0] idx;
  logic [4:0] sh;
  logic [3:0] mask;
  assign req_ready = rst && state == IDLE;
  assign resp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = LATENCY == 0 ? RESP : WAIT;
        cnt_n = 4'(LATENCY);
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        state_n = cnt == 4'd1 ? RESP : WAIT;
      end
      RESP: state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  assign enter = state_n == RESP && state != RESP;
  // with zero latency the access happens on the accept edge, so it must see the live request
  assign c_addr = state == IDLE ? req_addr : a_addr;
  assign c_wen = state == IDLE ? req_wen : a_wen;
  assign c_memop = state == IDLE ? req_memop : a_memop;
  assign c_wdata = state == IDLE ? req_wdata : a_wdata;
  assign off = c_addr - BASE;
  assign idx = off[AW+1:2];
  assign sh = {c_addr[1:0], 3'b000};
  assign word = mem[idx];
  assign lsh = word >> sh;
  // addresses below BASE wrap to huge offsets and fail the range test
  assign err = ({1'b0, off} >= LIM)
             || (c_memop[1:0] == 2'd1 && c_addr[0])
             || (c_memop[1:0] == 2'd2 && c_addr[1:0] != 2'd0)
             || (c_wen ? c_memop > 3'd2 : (c_memop[1:0] == 2'd3 || c_memop[2:1] == 2'b11));
  assign ld = c_memop[1:0] == 2'd0 ? {{24{~c_memop[2] & lsh[7]}}, lsh[7:0]}
            : c_memop[1:0] == 2'd1 ? {{16{~c_memop[2] & lsh[15]}}, lsh[15:0]} : word;
  assign mask = c_memop[1:0] == 2'd0 ? 4'b0001 << c_addr[1:0]
              : c_memop[1:0] == 2'd1 ? 4'b0011 << c_addr[1:0] : 4'b1111;
  assign wd = c_wdata << sh;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      a_addr <= '0;
      a_wen <= 1'b0;
      a_memop <= '0;
      a_wdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        a_addr <= req_addr;
        a_wen <= req_wen;
        a_memop <= req_memop;
        a_wdata <= req_wdata;
      end
      if (enter) begin
        resp_err <= err;
        resp_rdata <= (err || c_wen) ? '0 : ld;
      end
    end
  end
  // array has no reset; a store dropped by reset never reaches it
  always_ff @(posedge clk) begin
    if (rst && enter && c_wen && !err)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: randomized and directed checks of data_mem_resp against a byte-level memory model
module tb_data_mem_resp;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int DEPTH = 4096;
  localparam int LAT = 2;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_wen = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] req_memop = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic z_req_valid = 0, z_req_wen = 0, z_resp_ready = 1;
  logic [31:0] z_req_addr = 0, z_req_wdata = 0;
  logic [2:0] z_req_memop = 0;
  logic z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;
  int checks = 0, errors = 0;
  logic [7:0] mm [int unsigned];

  always #5 clk = ~clk;

  data_mem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_memop(req_memop), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  data_mem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .req_wen(z_req_wen), .req_memop(z_req_memop), .req_wdata(z_req_wdata), .resp_valid(z_resp_valid),
    .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err));

  function automatic void model(input logic [31:0] a, input logic w, input logic [2:0] op,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int unsigned off = a - BASE;
    int size = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : op[1:0] == 2'd2 ? 4 : 0;
    logic [31:0] v = 0;
    e = a < BASE || off >= 4 * DEPTH || size == 0 || (w ? op > 3'd2 : op == 3'd6)
        || (size > 1 && off % size != 0);
    rd = 0;
    if (!e)
      for (int i = 0; i < size; i++)
        if (w) mm[off + i] = wd[8*i +: 8];
        else v[8*i +: 8] = mm[off + i];
    if (!e && !w)
      rd = (op[2] || size == 4) ? v : size == 1 ? {{24{v[7]}}, v[7:0]} : {{16{v[15]}}, v[15:0]};
  endfunction

  task automatic txn(input logic [31:0] a, input logic w, input logic [2:0] op, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic e, output int lat);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    req_valid = 1; req_addr = a; req_wen = w; req_memop = op; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_wen = 1'($urandom); req_memop = 3'($urandom); req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata;
    e = resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      checks++;
      if (!(resp_valid === 1'b1 && resp_rdata === rd && resp_err === e && req_ready === 1'b0)) begin
        errors++;
        $display("FAIL hold_stable: valid=%b rdata=%h err=%b ready=%b, required valid=1 rdata=%h err=%b ready=0",
                 resp_valid, resp_rdata, resp_err, req_ready, rd, e);
      end
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++;
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_init;
    logic [31:0] rd, mrd;
    logic e, me;
    int lat;
    for (int i = 0; i < 17; i++) begin
      logic [31:0] a = i == 16 ? BASE + 4 * DEPTH - 4 : BASE + 4 * i;
      txn(a, 1, 3'b010, 0, 0, rd, e, lat);
      model(a, 1, 3'b010, 0, mrd, me);
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL init_err: addr %h got %b want 0", a, e); end
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd, mrd;
    logic e, me;
    int lat;
    txn(32'h80000010, 1, 3'b010, 32'hDEADBEEF, 0, rd, e, lat);
    model(32'h80000010, 1, 3'b010, 32'hDEADBEEF, mrd, me);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, e); end
    txn(32'h80000010, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_resp: got %h/%b want deadbeef/0", rd, e); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] addrs [4] = '{32'h80000011, 32'h80000013, 32'h80000012, 32'h80000010};
    logic [2:0] ops [4] = '{3'b000, 3'b000, 3'b101, 3'b010};
    logic [31:0] exps [4] = '{32'h0000007F, 32'hFFFFFFDE, 32'h0000DEAD, 32'hDEAD7FEF};
    logic [31:0] rd, mrd;
    logic e, me;
    int lat;
    txn(32'h80000011, 1, 3'b000, 32'h1234567F, 0, rd, e, lat);
    model(32'h80000011, 1, 3'b000, 32'h1234567F, mrd, me);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL sb_err: got %b want 0", e); end
    for (int i = 0; i < 4; i++) begin
      txn(addrs[i], 0, ops[i], 0, 0, rd, e, lat);
      checks++;
      if (rd !== exps[i] || e !== 1'b0)
        begin errors++; $display("FAIL lane_load_%0d: got %h/%b want %h/0", i, rd, e, exps[i]); end
    end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [6] = '{32'h80000002, 32'h80000001, 32'h7FFFFFFC, 32'h80000010, 32'h80000012, 32'h80000010};
    logic ws [6] = '{0, 0, 0, 0, 1, 1};
    logic [2:0] ops [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b010, 3'b011};
    logic [31:0] rd;
    logic e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      txn(addrs[i], ws[i], ops[i], 32'hFFFFFFFF, 0, rd, e, lat);
      checks++;
      if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL err_case_%0d: got %h/%b want 0/1", i, rd, e); end
    end
    txn(32'h80000010, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'hDEAD7FEF || e !== 1'b0) begin errors++; $display("FAIL err_nochange_10: got %h/%b want dead7fef/0", rd, e); end
    txn(32'h80000000, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL err_nochange_00: got %h/%b want 0/0", rd, e); end
  endtask

  task automatic test_bounds;
    logic [31:0] rd, mrd;
    logic e, me;
    int lat;
    txn(BASE + 4 * DEPTH - 4, 1, 3'b010, 32'hA5A55A5A, 0, rd, e, lat);
    model(BASE + 4 * DEPTH - 4, 1, 3'b010, 32'hA5A55A5A, mrd, me);
    txn(BASE + 4 * DEPTH - 4, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A55A5A || e !== 1'b0) begin errors++; $display("FAIL top_word: got %h/%b want a5a55a5a/0", rd, e); end
    txn(BASE + 4 * DEPTH, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL past_top: got %h/%b want 0/1", rd, e); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, mrd;
    logic e, me;
    int lat = 0;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h80000010; req_wen = 0; req_memop = 3'b010;
    @(posedge clk); #1;
    req_addr = 32'h80000014; req_wen = 1; req_wdata = 32'hCAFEF00D;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata;
    e = resp_err;
    checks++;
    if (rd !== 32'hDEAD7FEF || e !== 1'b0) begin errors++; $display("FAIL bp_resp: got %h/%b want dead7fef/0", rd, e); end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (!(resp_valid === 1'b1 && resp_rdata === rd && resp_err === e && req_ready === 1'b0)) begin
        errors++;
        $display("FAIL bp_hold: valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0", resp_valid, resp_rdata, resp_err, req_ready, rd, e);
      end
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL bp_after_hs: valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_reaccept: ready=%b want 0", req_ready); end
    lat = 0;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != LAT || resp_rdata !== 32'h0 || resp_err !== 1'b0)
      begin errors++; $display("FAIL bp_second: lat=%0d rdata=%h err=%b want %0d/0/0", lat, resp_rdata, resp_err, LAT); end
    model(32'h80000014, 1, 3'b010, 32'hCAFEF00D, mrd, me);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    txn(32'h80000014, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL bp_readback: got %h/%b want cafef00d/0", rd, e); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] rd;
    logic e;
    int lat;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h80000020; req_wen = 1; req_memop = 3'b010; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0)
      begin errors++; $display("FAIL midop_reset: valid=%b ready=%b want 0/0", resp_valid, req_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL midop_held: valid=%b want 0", resp_valid); end
    @(negedge clk);
    rst = 1;
    txn(32'h80000020, 0, 3'b010, 0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL midop_nowrite: got %h/%b want 0/0", rd, e); end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, mrd;
    logic [2:0] op;
    logic w, e, me;
    int lat;
    logic [2:0] good [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 80; n++) begin
      case ($urandom % 8)
        0: a = BASE - 4 * ($urandom % 4 + 1) + $urandom % 4;
        1: a = BASE + 4 * DEPTH + $urandom % 8;
        default: a = BASE + $urandom % 64;
      endcase
      w = 1'($urandom);
      op = $urandom % 4 != 0 ? good[$urandom % 5] : 3'($urandom);
      wd = $urandom;
      txn(a, w, op, wd, $urandom % 3, rd, e, lat);
      model(a, w, op, wd, mrd, me);
      checks++;
      if (rd !== mrd || e !== me)
        begin errors++; $display("FAIL rand_%0d: a=%h w=%b op=%0d got %h/%b want %h/%b", n, a, w, op, rd, e, mrd, me); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL rand_lat_%0d: got %0d want %0d", n, lat, LAT); end
    end
  endtask

  task automatic test_back_to_back_lat0;
    int done = 0;
    logic acc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      z_req_valid = 1; z_req_addr = BASE; z_req_memop = 3'b010;
      z_req_wen = i == 0; z_req_wdata = 32'h5EED1234;
      acc = z_req_ready;
      @(posedge clk); #1;
      checks++;
      if (z_resp_valid !== acc) begin errors++; $display("FAIL lat0_valid_%0d: got %b want %b", i, z_resp_valid, acc); end
      if (z_resp_valid === 1'b1) begin
        done++;
        checks++;
        if (z_resp_rdata !== (i == 0 ? 32'h0 : 32'h5EED1234) || z_resp_err !== 1'b0)
          begin errors++; $display("FAIL lat0_data_%0d: got %h/%b", i, z_resp_rdata, z_resp_err); end
      end
    end
    z_req_valid = 0;
    checks++;
    if (done != 10) begin errors++; $display("FAIL lat0_rate: got %0d responses want 10", done); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_bounds();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_back_to_back_lat0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
